// File: rtl/uart_matrix_txport_pkg.sv
// rtl/uart_matrix_txport_pkg.sv - UART frame constants and serializer state encoding
package uart_matrix_txport_pkg;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_matrix_txport_if.sv
// rtl/uart_matrix_txport_if.sv - matrix bus write side and FIFO status of one TX port
interface uart_matrix_txport_if #(
    parameter int depth = 16
) ();
    localparam int LW = $clog2(depth + 1);

    logic [7:0]    in;
    logic          in_cke;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          overflow;

    modport master (output in, in_cke, input full, empty, level, overflow);
    modport slave  (input in, in_cke, output full, empty, level, overflow);
endinterface

// File: rtl/uart_matrix_txport_ser.sv
// rtl/uart_matrix_txport_ser.sv - 8N1 serializer: bit divider, frame FSM, shift register
module uart_tx_ser
    import uart_matrix_txport_pkg::*;
#(
    parameter int div = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] data,
    input  logic       load,
    output logic       ready,
    output logic       out,
    output logic       busy
);
    localparam int            CW       = (div > 1) ? $clog2(div) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(div - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          out_q, out_d;
    logic          busy_q;
    logic          tick;

    assign tick  = (cnt_q == CNT_LAST);
    // Ready on the last clk of STOP lets the next frame start with no idle gap.
    assign ready = (state_q == ST_IDLE) || ((state_q == ST_STOP) && tick);
    assign out   = out_q;
    assign busy  = busy_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            out_q   <= STOP_BIT;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            out_q   <= out_d;
            busy_q  <= (state_q != ST_IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        out_d   = STOP_BIT;
        if (state_q != ST_IDLE) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
        unique case (state_q)
            ST_START: begin
                out_d = START_BIT;
                if (tick) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                out_d = shreg_q[0];
                if (tick) begin
                    shreg_d = shreg_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'(DATA_BITS - 1)) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) state_d = ST_IDLE;
            end
            default: ;
        endcase
        if (load) begin
            state_d = ST_START;
            shreg_d = data;
            cnt_d   = '0;
        end
    end
endmodule

// File: rtl/uart_matrix_txport.sv
// rtl/uart_matrix_txport.sv - matrix TX port: frame FIFO with status flags feeding an 8N1 serializer
module uart_matrix_txport
    import uart_matrix_txport_pkg::*;
#(
    parameter int depth = 16,
    parameter int div   = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    uart_matrix_txport_if.slave bus,
    output logic                out,
    output logic                busy
);
    localparam int AW = $clog2(depth);

    logic [7:0] mem_q [depth];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] level_q, level_d;
    logic        full_q, empty_q, overflow_q;
    logic        push, pop, ser_ready;
    logic [7:0]  head;

    // full is the registered pre-edge flag, so a write racing a pop is still dropped.
    assign push     = bus.in_cke && !full_q;
    assign pop      = ser_ready && !empty_q;
    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    assign level_d  = wr_ptr_d - rd_ptr_d;

    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.level    = level_q;
    assign bus.overflow = overflow_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= (level_d == (AW + 1)'(depth));
            empty_q    <= (level_d == '0);
            overflow_q <= overflow_q | (bus.in_cke & full_q);
        end
    end

    uart_tx_ser #(
        .div(div)
    ) u_ser (
        .clk    (clk),
        .reset_n(reset_n),
        .data   (head),
        .load   (pop),
        .ready  (ser_ready),
        .out    (out),
        .busy   (busy)
    );
endmodule

// File: tb/tb_uart_matrix_txport.sv
// tb/tb_uart_matrix_txport.sv - self-checking bench for uart_matrix_txport
module tb_uart_matrix_txport;
    localparam int N     = 4;
    localparam int DEPTH = 4;

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : (i == 1) ? 2 : (i == 2) ? 64 : 1;
    endfunction

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0][7:0] din;
    logic [N-1:0]      cke;
    logic [N-1:0]      out_w, busy_w, full_w, empty_w, ovf_w;
    logic [N-1:0][2:0] lvl_w;

    for (genvar g = 0; g < N; g++) begin : g_dut
        uart_matrix_txport_if #(.depth(DEPTH)) bus ();
        assign bus.in     = din[g];
        assign bus.in_cke = cke[g];
        assign full_w[g]  = bus.full;
        assign empty_w[g] = bus.empty;
        assign ovf_w[g]   = bus.overflow;
        assign lvl_w[g]   = bus.level;
        uart_matrix_txport #(.depth(DEPTH), .div(div_of(g))) dut (
            .clk    (clk),
            .reset_n(reset_n),
            .bus    (bus),
            .out    (out_w[g]),
            .busy   (busy_w[g])
        );
    end

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: FIFO as a queue; the line is a 10*div clk frame whose bits appear one clk late.
    logic [7:0]   mq [N][$];
    int           rem [N];
    logic [9:0]   mframe [N];
    logic [N-1:0] e_out, e_busy, e_ovf;

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            int d, idx;
            logic was_full, do_pop;
            if (!reset_n) begin
                mq[i].delete();
                rem[i] = 0;
                e_out[i] = 1'b1;
                e_busy[i] = 1'b0;
                e_ovf[i] = 1'b0;
            end
            chk($sformatf("out[%0d]", i), 32'(out_w[i]), 32'(e_out[i]));
            chk($sformatf("busy[%0d]", i), 32'(busy_w[i]), 32'(e_busy[i]));
            chk($sformatf("level[%0d]", i), 32'(lvl_w[i]), 32'(mq[i].size()));
            chk($sformatf("full[%0d]", i), 32'(full_w[i]), 32'(mq[i].size() == DEPTH));
            chk($sformatf("empty[%0d]", i), 32'(empty_w[i]), 32'(mq[i].size() == 0));
            chk($sformatf("overflow[%0d]", i), 32'(ovf_w[i]), 32'(e_ovf[i]));
            if (reset_n) begin
                d = div_of(i);
                if (rem[i] == 0) begin
                    e_out[i] = 1'b1;
                end else begin
                    idx = (10 * d - rem[i]) / d;
                    e_out[i] = mframe[i][idx];
                end
                e_busy[i] = (rem[i] != 0);
                was_full = (mq[i].size() == DEPTH);
                do_pop = (rem[i] <= 1) && (mq[i].size() != 0);
                if (rem[i] > 0) rem[i]--;
                if (do_pop) begin
                    mframe[i] = {1'b1, mq[i].pop_front(), 1'b0};
                    rem[i] = 10 * d;
                end
                if (cke[i]) begin
                    if (was_full) e_ovf[i] = 1'b1;
                    else mq[i].push_back(din[i]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write1(input int i, input logic [7:0] v);
        din[i] = v;
        cke[i] = 1'b1;
        step();
        cke[i] = 1'b0;
    endtask

    initial begin
        logic [9:0] a5_bits;
        int busy_cnt, lvl_max, w1;
        din = '0;
        cke = '0;
        a5_bits = {1'b1, 8'hA5, 1'b0};
        repeat (3) step();
        @(negedge clk);
        chk("rst_out", 32'(out_w[0]), 1);
        chk("rst_empty", 32'(empty_w[0]), 1);
        chk("rst_level", 32'(lvl_w[0]), 0);
        chk("rst_busy", 32'(busy_w[0]), 0);
        step();
        reset_n = 1'b1;
        step();

        // 0xA5 on div=4
        write1(0, 8'hA5);
        @(negedge clk);
        chk("a5_empty_after_t", 32'(empty_w[0]), 0);
        @(negedge clk);
        chk("a5_out_t1", 32'(out_w[0]), 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("a5_bit%0d", k), 32'(out_w[0]), 32'(a5_bits[k]));
            repeat (3) @(negedge clk);
        end
        @(negedge clk);
        chk("a5_busy_end", 32'(busy_w[0]), 0);
        step();

        // burst of three on div=2
        din[1] = 8'h01; cke[1] = 1'b1; step();
        din[1] = 8'h02; step();
        din[1] = 8'h03; step();
        cke[1] = 1'b0;
        busy_cnt = 0;
        lvl_max = 0;
        repeat (80) begin
            @(negedge clk);
            if (busy_w[1]) busy_cnt++;
            if (int'(lvl_w[1]) > lvl_max) lvl_max = int'(lvl_w[1]);
        end
        chk("burst_busy_clks", 32'(busy_cnt), 60);
        chk("burst_level_peak", 32'(lvl_max), 2);
        step();

        // fill depth=4 on div=64, then overflow
        din[2] = 8'h11; cke[2] = 1'b1; step();
        w1 = cyc;
        din[2] = 8'h22; step();
        din[2] = 8'h33; step();
        din[2] = 8'h44; step();
        din[2] = 8'h55; step();
        cke[2] = 1'b0;
        @(negedge clk);
        chk("fill_full", 32'(full_w[2]), 1);
        chk("fill_level", 32'(lvl_w[2]), 4);
        chk("fill_ovf_clear", 32'(ovf_w[2]), 0);
        step();
        write1(2, 8'hEE);
        @(negedge clk);
        chk("ovf_set", 32'(ovf_w[2]), 1);
        chk("ovf_level", 32'(lvl_w[2]), 4);
        chk("ovf_full", 32'(full_w[2]), 1);
        step();
        while (cyc < w1 + 640) step();
        write1(2, 8'hDD);
        @(negedge clk);
        chk("race_level", 32'(lvl_w[2]), 3);
        chk("race_full", 32'(full_w[2]), 0);
        chk("race_ovf", 32'(ovf_w[2]), 1);
        step();
        repeat (2600) step();

        // reset in the middle of data bit 3 of 0xFF
        write1(0, 8'hFF);
        repeat (20) @(negedge clk);
        chk("mid_busy", 32'(busy_w[0]), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out", 32'(out_w[0]), 1);
        chk("arst_busy", 32'(busy_w[0]), 0);
        chk("arst_empty", 32'(empty_w[0]), 1);
        chk("arst_ovf", 32'(ovf_w[2]), 0);
        step();
        step();
        reset_n = 1'b1;
        step();
        write1(0, 8'h00);
        repeat (3) @(negedge clk);
        chk("zero_start", 32'(out_w[0]), 0);
        repeat (32) @(negedge clk);
        chk("zero_bit7", 32'(out_w[0]), 0);
        repeat (4) @(negedge clk);
        chk("zero_stop", 32'(out_w[0]), 1);
        step();
        repeat (10) step();

        // 0x80 on div=1
        write1(3, 8'h80);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("d1_out%0d", k), 32'(out_w[3]), (k < 8) ? 32'd0 : 32'd1);
            chk($sformatf("d1_busy%0d", k), 32'(busy_w[3]), (k < 10) ? 32'd1 : 32'd0);
        end
        step();
        repeat (5) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/uart_matrix_txport.md
Name: uart_matrix_txport

Overview:
- One physical TX port fed by the shared matrix bus: 8-bit data plus an individual write strike.
- Buffers frames in an internal FIFO and serializes them 8N1, LSB first, onto one UART line.
- One instance per TX port. All instances share the data bus; each gets its own cke bit.
- Counterpart of the matrix RX path: the matrix delivers a frame in one clk, and this block drains it at line rate.

Parameters:
- depth, 16: FIFO depth in frames. Power of two, ≥2.
- div, 16: clk cycles per UART bit. ≥1.

Ports:
- clk  input  1  master clock; the same clock as the matrix.
- reset_n  input  1  asynchronous, active-low reset.
- in  input  8  parallel frame from the shared matrix bus.
- in_cke  input  1  write strobe; one frame per asserted cycle.
- out  output  1  serial UART line; idles high.
- full  output  1  FIFO holds depth frames.
- empty  output  1  FIFO holds 0 frames.
- level  output  $clog2(depth+1)  current FIFO occupancy.
- overflow  output  1  sticky flag: a frame was dropped.
- busy  output  1  serializer is mid-frame.

Behaviour:
- Reset values (reset_n low, asynchronous): out=1, empty=1, full=0, level=0, overflow=0, busy=0. Pointers, bit counter and divider counter are cleared.
- Reset mid-frame: the frame is aborted, out returns high at once, and buffered frames are discarded. Operation resumes on the first clk edge after reset_n rises.
- Write:
  - If in_cke=1 and full=0 at the edge, in is stored at the write pointer and the pointer advances (mod depth).
  - If in_cke=1 while full=1, the frame is dropped and overflow is set. overflow stays set until reset.
  - full is evaluated before that cycle's pop. A write while full is dropped even if a pop happens on the same edge.
- Pop: happens when the serializer is in IDLE and empty=0. The frame is latched into the shift register and the read pointer advances.
- Simultaneous push and pop (not full, not empty): level is unchanged and both pointers advance.
- level, full and empty are registered and consistent with the pointers every cycle. level = wr_ptr − rd_ptr using one extra wrap bit.
- Serializer FSM: IDLE → START → DATA → STOP → (IDLE, or START again).
  - IDLE: out=1, busy=0. On a pop, go to START.
  - START: out=0 for div clks.
  - DATA: 8 bits, LSB first, each held div clks. A 3-bit counter wraps 7→0 and then moves to STOP.
  - STOP: out=1 for div clks. At the end of STOP, if empty=0, pop in the same cycle and go directly to START (no idle gap). Otherwise go to IDLE.
  - busy=1 in START, DATA and STOP.
- Divider: counts 0..div−1. The bit boundary is at count=div−1, where it wraps to 0. With div=1 every clk is a bit boundary.
- Latency: with the FIFO empty and the serializer idle, a write at edge t gives empty=0 after t. The pop is at edge t+1 and out falls after edge t+2.
- Frame duration: exactly 10·div clks. Back-to-back frames: the next start bit follows the stop bit immediately.
- out is driven straight from a register, so it is glitch-free.

Decomposition:
- Shared header (`include, guarded): frame constants START_BIT=0, STOP_BIT=1, DATA_BITS=8, plus FSM state encodings, shared with the RX side.
- Sub-module uart_tx_ser: divider, FSM and shift register.
  - Interface: clk, reset_n, data[8], load (pulse), ready, out.
  - The top level holds the FIFO and flags and drives load=ready & !empty.

Test Plan:
- Reset with div=4: out=1, empty=1, level=0. Write 0xA5 → out = 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 clks. The start bit appears 2 clks after the write edge.
- Burst of 3 writes (0x01, 0x02, 0x03) on consecutive clks, div=2 → level peaks at 2 (one frame already popped). The three frames are contiguous with no idle gap: total 60 clks of busy=1.
- Fill depth=4 with the serializer stalled by a large div (div=64); write a 5th frame → full=1, overflow=1, level=4. The 5th frame never appears on out.
- Write while full on the same edge as the end-of-STOP pop → the write is dropped, overflow=1, level drops to 3.
- Assert reset_n=0 in the middle of the DATA bit 3 of 0xFF → out=1 immediately, empty=1, overflow=0. A subsequent 0x00 write transmits a clean frame.
- div=1, write 0x80 → out is low for 8 clks (start bit plus bits 0–6), then high for 2 clks (bit 7 and stop). busy deasserts 10 clks after the start bit.
